sdiv_fixed: RTL

- Parametrised, sequential, signed fixed-point divider for the lock-loop datapath.
- Computes out = (in0 << frac) / in1, truncated toward zero, using radix-2 restoring division on magnitudes.
- Adds remainder output, saturation, an overflow flag, a divide-by-zero flag, an explicit busy/done handshake and selectable pass-through modes.
- Sits between the error/gain arithmetic and the output scaling stage, replacing the fixed 16-bit divider.

---
 rtl/sdiv_pkg.sv | 13 +
 rtl/sdiv_step.sv | 19 +
 rtl/sdiv_fixed.sv | 104 ++++++++++
 3 files changed

// File: rtl/sdiv_pkg.sv
// sdiv_pkg: shared encodings, FSM states and saturation limits for sdiv_fixed
package sdiv_pkg;
    localparam logic [1:0] MODE_DIV   = 2'd0;
    localparam logic [1:0] MODE_PASS0 = 2'd1;
    localparam logic [1:0] MODE_PASS1 = 2'd2;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    function automatic longint sat_max(int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction
    function automatic longint sat_min(int w);
        return -(longint'(1) << (w - 1));
    endfunction
endpackage

// File: rtl/sdiv_step.sv
// sdiv_step: one restoring-division iteration on a W+1-bit partial remainder
module sdiv_step
    import sdiv_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W:0]   pr,
    input  logic         din,
    input  logic [W-1:0] dvs,
    output logic [W:0]   pr_n,
    output logic         q
);
    logic [W+1:0] diff;
    always_comb begin
        diff = {pr, din} - {2'b00, dvs};
        q    = ~diff[W+1];
        pr_n = q ? diff[W:0] : {pr[W-1:0], din};
    end
endmodule

// File: rtl/sdiv_fixed.sv
// sdiv_fixed: sequential signed fixed-point divider with saturation, remainder and pass-through
module sdiv_fixed
    import sdiv_pkg::*;
#(
    parameter int W = 16,
    parameter int FMAX = 15,
    localparam int FW = (FMAX < 1) ? 1 : $clog2(FMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] frac,
    input  logic [W-1:0]  in0,
    input  logic [W-1:0]  in1,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  out,
    output logic [W-1:0]  rem,
    output logic          ovf,
    output logic          dz
);
    localparam int N = W + FMAX;
    localparam int CW = $clog2(N);
    localparam logic [W-1:0]  SMAX  = W'(sat_max(W));
    localparam logic [W-1:0]  SMIN  = W'(sat_min(W));
    localparam logic [N-1:0]  QMAXP = N'(sat_max(W));
    localparam logic [N-1:0]  QMAXN = N'(-sat_min(W));
    localparam logic [FW-1:0] FCAP  = FW'(FMAX);
    state_t state, state_n;
    logic [N-1:0] dq;
    logic [W:0] pr, pr_n;
    logic [W-1:0] dvs, mag0, mag1, res, rres;
    logic [FW-1:0] fc;
    logic [CW-1:0] cnt;
    logic neg0, neg1, qb, zd, sneg, big_pos, big_neg, ovf_n;
    sdiv_step #(.W(W)) u_step (.pr(pr), .din(dq[N-1]), .dvs(dvs), .pr_n(pr_n), .q(qb));
    assign busy = state != IDLE;
    always_comb begin
        mag0    = in0[W-1] ? -in0 : in0;
        mag1    = in1[W-1] ? -in1 : in1;
        fc      = frac > FCAP ? FCAP : frac;
        zd      = dvs == '0;
        sneg    = neg0 ^ neg1;
        big_pos = dq > QMAXP;
        big_neg = dq > QMAXN;
        ovf_n   = !zd && (sneg ? big_neg : big_pos);
        res     = zd ? (neg0 ? SMIN : SMAX) :
                  sneg ? (big_neg ? SMIN : -dq[W-1:0]) : (big_pos ? SMAX : dq[W-1:0]);
        rres    = zd ? '0 : neg0 ? -pr[W-1:0] : pr[W-1:0];
    end
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = start && mode == MODE_DIV ? RUN : IDLE;
        else if (state == RUN)
            state_n = cnt == CW'(N - 1) ? FIN : RUN;
        else
            state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out  <= '0;
            rem  <= '0;
            ovf  <= 1'b0;
            dz   <= 1'b0;
            done <= 1'b0;
            neg0 <= 1'b0;
            neg1 <= 1'b0;
            dq   <= '0;
            pr   <= '0;
            dvs  <= '0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start && mode == MODE_DIV) begin
                neg0 <= in0[W-1];
                neg1 <= in1[W-1];
                dq   <= N'(mag0) << fc;
                dvs  <= mag1;
                pr   <= '0;
                cnt  <= '0;
            end else if (state == IDLE && start) begin
                out  <= mode == MODE_PASS1 ? in1 : in0;
                rem  <= '0;
                ovf  <= 1'b0;
                dz   <= 1'b0;
                done <= 1'b1;
            end else if (state == RUN) begin
                pr  <= pr_n;
                dq  <= {dq[N-2:0], qb};
                cnt <= cnt + 1'b1;
            end else if (state == FIN) begin
                out  <= res;
                rem  <= rres;
                ovf  <= ovf_n;
                dz   <= zd;
                done <= 1'b1;
            end
        end
endmodule
